// File: rtl/id_ex_front_pipe.sv
// id_ex_front_pipe
//   Front half of a 5-stage MIPS datapath: IF/ID register, ID/EX register,
//   and the execute-stage ALU with its operand forwarding muxes.
//
// Ports
//   clk, reset            rising-edge clock; synchronous active-high reset
//   StallD, CLR           IF/ID hold / flush-to-NOP (stall wins over flush)
//   RD_ROM, PCPlus4F      fetched instruction and its PC+4
//   InstrD, PCPlus4D      IF/ID register contents
//   RsD, RtD, RdD         register fields of InstrD
//   FlushE                bubble insert into ID/EX
//   *D controls/operands  decoded controls, immediate, register read data
//   *E outputs            ID/EX register contents
//   WriteRegE             destination register (Rd or Rt by RegDstE)
//   ResultW, ALUOutM      forwarding sources from WB and MEM
//   ForwardAE, ForwardBE  forward selects: 01 WB, 10 MEM, 00/11 register
//   ALUOutE, WriteDataE   ALU result and forwarded store data
module id_ex_front_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        CLR,
  input  logic [31:0] RD_ROM,
  input  logic [31:0] PCPlus4F,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic [4:0]  RdD,
  input  logic        FlushE,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        MemWriteD,
  input  logic        ALUSrcD,
  input  logic        RegDstD,
  input  logic [3:0]  ALUCtrD,
  input  logic [31:0] SignImmD,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        RegDstE,
  output logic [3:0]  ALUCtrE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] SignImmE,
  output logic [4:0]  WriteRegE,
  input  logic [31:0] ResultW,
  input  logic [31:0] ALUOutM,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  output logic [31:0] ALUOutE,
  output logic [31:0] WriteDataE
);

  localparam int DATA_W = 32;

  logic signed [DATA_W-1:0] src_a;
  logic signed [DATA_W-1:0] fwd_b;
  logic signed [DATA_W-1:0] src_b;

  // Forward select decode; codes 00 and 11 both take the register value.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] wb_val,
    input logic [DATA_W-1:0] mem_val
  );
    case (sel)
      2'b01:   return wb_val;
      2'b10:   return mem_val;
      default: return reg_val;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] alu(
    input logic [3:0]               ctl,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    case (ctl)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return ~(a | b);
      4'b0110: return a - b;
      4'b0111: return {{(DATA_W-1){1'b0}}, (a < b)};
      4'b1000: return {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      4'b1001: return {b[15:0], 16'b0};
      default: return '0;
    endcase
  endfunction

  // ---- F -> D boundary: IF/ID register ----
  // Stall is checked before CLR so a stalled branch target is never dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
    end else if (!StallD) begin
      if (CLR) begin
        InstrD   <= '0;
        PCPlus4D <= '0;
      end else begin
        InstrD   <= RD_ROM;
        PCPlus4D <= PCPlus4F;
      end
    end
  end

  assign RsD = InstrD[25:21];
  assign RtD = InstrD[20:16];
  assign RdD = InstrD[15:11];

  // ---- D -> E boundary: ID/EX register (flush inserts an all-zero bubble) ----
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      MemWriteE <= 1'b0;
      ALUSrcE   <= 1'b0;
      RegDstE   <= 1'b0;
      ALUCtrE   <= '0;
      RsE       <= '0;
      RtE       <= '0;
      RdE       <= '0;
      RD1E      <= '0;
      RD2E      <= '0;
      SignImmE  <= '0;
    end else begin
      RegWriteE <= RegWriteD;
      MemtoRegE <= MemtoRegD;
      MemWriteE <= MemWriteD;
      ALUSrcE   <= ALUSrcD;
      RegDstE   <= RegDstD;
      ALUCtrE   <= ALUCtrD;
      RsE       <= RsD;
      RtE       <= RtD;
      RdE       <= RdD;
      RD1E      <= RD1;
      RD2E      <= RD2;
      SignImmE  <= SignImmD;
    end
  end

  assign WriteRegE = RegDstE ? RdE : RtE;

  // ---- E stage: forwarding and ALU (combinational) ----
  always_comb begin
    src_a = fwd_sel(ForwardAE, RD1E, ResultW, ALUOutM);
    fwd_b = fwd_sel(ForwardBE, RD2E, ResultW, ALUOutM);
    src_b = ALUSrcE ? SignImmE : fwd_b;
  end

  assign WriteDataE = fwd_b;
  assign ALUOutE    = alu(ALUCtrE, src_a, src_b);

endmodule

// File: tb/tb_id_ex_front_pipe.sv
module tb_id_ex_front_pipe;

  logic        clk = 1'b0;
  logic        reset, StallD, CLR, FlushE;
  logic [31:0] RD_ROM, PCPlus4F;
  logic [31:0] InstrD, PCPlus4D;
  logic [4:0]  RsD, RtD, RdD;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [3:0]  ALUCtrD;
  logic [31:0] SignImmD, RD1, RD2;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [3:0]  ALUCtrE;
  logic [4:0]  RsE, RtE, RdE, WriteRegE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [31:0] ResultW, ALUOutM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUOutE, WriteDataE;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_front_pipe dut (
    .clk(clk), .reset(reset), .StallD(StallD), .CLR(CLR),
    .RD_ROM(RD_ROM), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUCtrD(ALUCtrD),
    .SignImmD(SignImmD), .RD1(RD1), .RD2(RD2),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUCtrE(ALUCtrE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E),
    .SignImmE(SignImmE), .WriteRegE(WriteRegE), .ResultW(ResultW),
    .ALUOutM(ALUOutM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        regwrite, memtoreg, memwrite, alusrc, regdst;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm;
  } e_stage_t;

  logic [31:0] m_instr, m_pc;
  e_stage_t    m_e;
  bit          model_ok = 0;

  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return ALUOutM;
    return r;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic lt;
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return ~a & ~b;
      4'd6: return a + (~b + 32'd1);
      4'd7: begin
        lt = (a[31] != b[31]) ? a[31] : (a < b);
        return {31'd0, lt};
      end
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      4'd9: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset || FlushE) begin
      m_e = '{default: '0};
    end else begin
      m_e.regwrite = RegWriteD; m_e.memtoreg = MemtoRegD; m_e.memwrite = MemWriteD;
      m_e.alusrc = ALUSrcD; m_e.regdst = RegDstD; m_e.op = ALUCtrD;
      m_e.rs = m_instr[25:21]; m_e.rt = m_instr[20:16]; m_e.rd = m_instr[15:11];
      m_e.a = RD1; m_e.b = RD2; m_e.imm = SignImmD;
    end
    if (reset) begin
      m_instr = 0; m_pc = 0; model_ok = 1;
    end else if (StallD) begin
      m_instr = m_instr;
    end else if (CLR) begin
      m_instr = 0; m_pc = 0;
    end else begin
      m_instr = RD_ROM; m_pc = PCPlus4F;
    end
  end

  always @(negedge clk) begin
    logic [31:0] fb;
    if (model_ok) begin
      fb = m_fwd(ForwardBE, m_e.b);
      check("m_InstrD", InstrD, m_instr);
      check("m_PCPlus4D", PCPlus4D, m_pc);
      check("m_RsD", 32'(RsD), 32'(m_instr[25:21]));
      check("m_RtD", 32'(RtD), 32'(m_instr[20:16]));
      check("m_RdD", 32'(RdD), 32'(m_instr[15:11]));
      check("m_ctrlE", 32'({RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUCtrE}),
            32'({m_e.regwrite, m_e.memtoreg, m_e.memwrite, m_e.alusrc, m_e.regdst, m_e.op}));
      check("m_RsE", 32'(RsE), 32'(m_e.rs));
      check("m_RtE", 32'(RtE), 32'(m_e.rt));
      check("m_RdE", 32'(RdE), 32'(m_e.rd));
      check("m_RD1E", RD1E, m_e.a);
      check("m_RD2E", RD2E, m_e.b);
      check("m_SignImmE", SignImmE, m_e.imm);
      check("m_WriteRegE", 32'(WriteRegE), 32'(m_e.regdst ? m_e.rd : m_e.rt));
      check("m_WriteDataE", WriteDataE, fb);
      check("m_ALUOutE", ALUOutE,
            m_alu(m_e.op, m_fwd(ForwardAE, m_e.a), m_e.alusrc ? m_e.imm : fb));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct { logic [3:0] op; logic [31:0] exp; string name; } alu_vec_t;
  alu_vec_t vecs[9] = '{
    '{4'd2, 32'd12,         "ADD"},
    '{4'd6, 32'd2,          "SUB"},
    '{4'd0, 32'd5,          "AND"},
    '{4'd1, 32'd7,          "OR"},
    '{4'd3, 32'd2,          "XOR"},
    '{4'd7, 32'd0,          "SLT"},
    '{4'd4, 32'hFFFFFFF8,   "NOR"},
    '{4'd8, 32'd0,          "SLTU"},
    '{4'd5, 32'd0,          "UNUSED5"}
  };

  initial begin
    // Reset with nonzero inputs everywhere
    reset = 1; StallD = 0; CLR = 0; FlushE = 0;
    RD_ROM = 32'hDEADBEEF; PCPlus4F = 32'h44;
    RegWriteD = 1; MemtoRegD = 1; MemWriteD = 1; ALUSrcD = 1; RegDstD = 1;
    ALUCtrD = 4'd2; SignImmD = 32'h55; RD1 = 32'h5; RD2 = 32'h6;
    ResultW = 0; ALUOutM = 0; ForwardAE = 0; ForwardBE = 0;
    tick();
    check("rst_InstrD", InstrD, 32'd0);
    check("rst_PCPlus4D", PCPlus4D, 32'd0);
    check("rst_RegWriteE", 32'(RegWriteE), 32'd0);
    check("rst_MemWriteE", 32'(MemWriteE), 32'd0);
    check("rst_RD1E", RD1E, 32'd0);
    check("rst_ALUOutE", ALUOutE, 32'd0);
    reset = 0;

    // IF/ID path
    RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; ALUSrcD = 0; RegDstD = 0;
    RD_ROM = 32'h2001000A; PCPlus4F = 32'd4;
    tick();
    check("ifid_InstrD", InstrD, 32'h2001000A);
    check("ifid_RsD", 32'(RsD), 32'd0);
    check("ifid_RtD", 32'(RtD), 32'd1);
    check("ifid_PCPlus4D", PCPlus4D, 32'd4);
    StallD = 1; RD_ROM = 32'h11111111; PCPlus4F = 32'd8;
    tick();
    check("stall_InstrD", InstrD, 32'h2001000A);
    check("stall_PCPlus4D", PCPlus4D, 32'd4);
    CLR = 1;
    tick();
    check("stallclr_InstrD", InstrD, 32'h2001000A);
    check("stallclr_PCPlus4D", PCPlus4D, 32'd4);
    StallD = 0;
    tick();
    check("clr_InstrD", InstrD, 32'd0);
    check("clr_PCPlus4D", PCPlus4D, 32'd0);
    CLR = 0;

    // ID/EX and write register: add $3,$0,$2 -> rt=2, rd=3
    RD_ROM = 32'h00021820; PCPlus4F = 32'd12;
    tick();
    RegWriteD = 1; RegDstD = 1;
    tick();
    check("idex_RegWriteE", 32'(RegWriteE), 32'd1);
    check("idex_WriteRegE_rd", 32'(WriteRegE), 32'd3);
    RegDstD = 0;
    tick();
    check("idex_WriteRegE_rt", 32'(WriteRegE), 32'd2);
    FlushE = 1;
    tick();
    check("flush_RegWriteE", 32'(RegWriteE), 32'd0);
    check("flush_WriteRegE", 32'(WriteRegE), 32'd0);
    check("flush_RD2E", RD2E, 32'd0);
    FlushE = 0;

    // ALU ops with RD1E=7, RD2E=5
    RD1 = 32'd7; RD2 = 32'd5; ALUSrcD = 0; SignImmD = 32'd0;
    foreach (vecs[i]) begin
      ALUCtrD = vecs[i].op;
      tick();
      check({"alu_", vecs[i].name}, ALUOutE, vecs[i].exp);
    end

    // Signed vs unsigned compare, then LUI from immediate
    RD1 = 32'hFFFFFFFF; RD2 = 32'd1; ALUCtrD = 4'd7;
    tick();
    check("alu_SLT_neg", ALUOutE, 32'd1);
    ALUCtrD = 4'd8;
    tick();
    check("alu_SLTU_big", ALUOutE, 32'd0);
    ALUSrcD = 1; SignImmD = 32'h1234; ALUCtrD = 4'd9;
    tick();
    check("alu_LUI", ALUOutE, 32'h12340000);
    check("lui_WriteDataE", WriteDataE, 32'd1);

    // Forwarding
    RD1 = 32'd1; RD2 = 32'd2; ALUSrcD = 0; ALUCtrD = 4'd2;
    ALUOutM = 32'd100; ResultW = 32'd50;
    tick();
    check("fwd_none", ALUOutE, 32'd3);
    ForwardAE = 2'b10; #1;
    check("fwd_A_mem", ALUOutE, 32'd102);
    ForwardAE = 2'b01; #1;
    check("fwd_A_wb", ALUOutE, 32'd52);
    ForwardAE = 2'b00; ForwardBE = 2'b10; #1;
    check("fwd_B_mem", ALUOutE, 32'd101);
    check("fwd_B_mem_wd", WriteDataE, 32'd100);
    ForwardBE = 2'b01; #1;
    check("fwd_B_wb", ALUOutE, 32'd51);
    ForwardBE = 2'b00; ForwardAE = 2'b11; #1;
    check("fwd_A_11", ALUOutE, 32'd3);
    ForwardAE = 2'b00;

    // Subtraction wrap-around
    RD1 = 32'd0; RD2 = 32'd1; ALUCtrD = 4'd6;
    tick();
    check("alu_SUB_wrap", ALUOutE, 32'hFFFFFFFF);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_front_pipe.md
Name: id_ex_front_pipe

Overview:
- Front half of the 5-stage MIPS pipeline datapath.
- Contains the IF/ID pipeline register, the ID/EX pipeline register, and the execute-stage ALU with its forwarding muxes.
- Takes the fetched instruction and decoded control/operands, and produces the EX-stage ALU result, store data and destination register for the EX/MEM register.

Parameters:
- none (datapath fixed at 32 bits, register index 5 bits, ALU control 4 bits)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears both pipeline registers
- StallD  in  1  hold IF/ID contents
- CLR  in  1  flush IF/ID (branch/jump taken)
- RD_ROM  in  32  fetched instruction (F stage)
- PCPlus4F  in  32  PC+4 of fetched instruction
- InstrD  out  32  registered instruction
- PCPlus4D  out  32  registered PC+4
- RsD, RtD, RdD  out  5  InstrD[25:21], [20:16], [15:11] (combinational)
- FlushE  in  1  insert bubble into ID/EX
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1  decoded controls
- ALUCtrD  in  4  decoded ALU operation
- SignImmD, RD1, RD2  in  32  sign-extended immediate, register-file read data
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1  registered controls
- ALUCtrE  out  4  registered ALU operation
- RsE, RtE, RdE  out  5  registered register indices
- RD1E, RD2E, SignImmE  out  32  registered operands
- WriteRegE  out  5  RegDstE ? RdE : RtE (combinational)
- ResultW  in  32  WB-stage result (forward source)
- ALUOutM  in  32  MEM-stage ALU result (forward source)
- ForwardAE, ForwardBE  in  2  forward selects
- ALUOutE  out  32  ALU result
- WriteDataE  out  32  forwarded B operand (store data)

Behaviour:

IF/ID register, rising clk, priority reset > StallD > CLR > load:
- reset: InstrD = 0, PCPlus4D = 0.
- StallD: hold both registers.
- CLR: InstrD = 0 (NOP), PCPlus4D = 0.
- Otherwise: InstrD <= RD_ROM, PCPlus4D <= PCPlus4F.
- Stall outranks CLR so a stalled branch is never lost.

ID/EX register, rising clk:
- reset or FlushE: every E output register = 0 (bubble: no reg write, no mem write).
- Otherwise: capture all D inputs, including RsD, RtD, RdD into RsE, RtE, RdE.
- There is no stall on this stage.

Forwarding (combinational):
- SrcA = ForwardAE: 00 -> RD1E, 01 -> ResultW, 10 -> ALUOutM, 11 -> RD1E.
- Forwarded B uses ForwardBE with the same encoding on RD2E.
- WriteDataE = forwarded B.
- SrcB = ALUSrcE ? SignImmE : forwarded B.

ALU (combinational, 32-bit, wrap-around, no overflow flag), by ALUCtrE:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 NOR
- 0110 SUB (A-B)
- 0111 SLT, signed: 1 if A<B else 0
- 1000 SLTU, unsigned
- 1001 LUI (SrcB<<16)
- any other code -> 0

Latency:
- RD_ROM to InstrD: 1 cycle.
- D inputs to E outputs: 1 cycle.
- ALU and forwarding: 0 cycles.

Test Plan:
- Reset: assert reset with nonzero inputs for one edge -> InstrD, PCPlus4D and all E outputs = 0, ALUOutE = 0 (ALUCtrE=0000 AND of zeros).
- IF/ID path: RD_ROM=0x2001000A, PCPlus4F=4 -> next edge InstrD=0x2001000A, RsD=0, RtD=1, PCPlus4D=4. StallD=1 with new RD_ROM -> values held. CLR=1 -> InstrD=0. StallD=1 and CLR=1 together -> values held.
- ID/EX and write register: RegWriteD=1, RegDstD=1, RdD=3, RtD=2 -> after edge RegWriteE=1, WriteRegE=3; RegDstD=0 -> WriteRegE=2. FlushE=1 -> all E outputs 0.
- ALU ops, RD1E=7, RD2E=5, forwards 00, ALUSrcE=0:
  - ADD -> 12
  - SUB -> 2
  - AND -> 5
  - OR -> 7
  - XOR -> 2
  - SLT -> 0
  - NOR -> 0xFFFFFFF8
- Signed/unsigned compare and immediate: RD1E=0xFFFFFFFF, RD2E=1 -> SLT = 1, SLTU = 0. ALUSrcE=1, SignImmE=0x1234, LUI -> 0x12340000; WriteDataE still = RD2E.
- Forwarding: RD1E=1, ALUOutM=100, ResultW=50, RD2E=2, ADD:
  - ForwardAE=10 -> 102
  - ForwardAE=01 -> 52
  - ForwardBE=10 with AE=00 -> 101, and WriteDataE=100
  - ForwardAE=11 -> 3
